// File: rtl/eth_idma_req_sched.sv
// eth_idma_req_sched
//
// Schedules iDMA transfer requests from the Ethernet TX (mem->stream) and
// RX (stream->mem) requesters onto one shared iDMA backend. The block
// arbitrates round-robin, holds the grant until the backend accepts it, and
// caps the number of in-flight transfers. Backend responses come back in
// order and are routed to the requester that issued the matching request.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   tx_req_*/rx_req_*            requester descriptor valid/ready channels
//   tx_rsp_*/rx_rsp_*            per-requester response channels
//   be_req_*/be_rsp_*            backend request / response channels
//   outstanding_o                transfers accepted by the backend, not yet answered
//   busy_o                       transfers in flight or a grant is held
//   rsp_orphan_o                 backend response arrived with nothing outstanding
//
// Build option:
//   ETH_IDMA_SCHED_RX_PRIO_EN    when defined, RX has strict priority over TX
//                                instead of round-robin.

package eth_idma_pkg;

    typedef struct packed {
        logic [31:0] src_addr;
        logic [31:0] dst_addr;
        logic [15:0] length;
    } idma_req_t;

    typedef struct packed {
        logic        error;
        logic [15:0] bytes_done;
    } idma_rsp_t;

endpackage

module eth_idma_req_sched #(
    parameter int unsigned MaxOutstanding = 4,
    parameter type         idma_req_t     = eth_idma_pkg::idma_req_t,
    parameter type         idma_rsp_t     = eth_idma_pkg::idma_rsp_t
) (
    input  logic                                clk_i,
    input  logic                                rst_i,

    input  idma_req_t                           tx_req_i,
    input  logic                                tx_req_valid_i,
    output logic                                tx_req_ready_o,
    output idma_rsp_t                           tx_rsp_o,
    output logic                                tx_rsp_valid_o,
    input  logic                                tx_rsp_ready_i,

    input  idma_req_t                           rx_req_i,
    input  logic                                rx_req_valid_i,
    output logic                                rx_req_ready_o,
    output idma_rsp_t                           rx_rsp_o,
    output logic                                rx_rsp_valid_o,
    input  logic                                rx_rsp_ready_i,

    output idma_req_t                           be_req_o,
    output logic                                be_req_valid_o,
    input  logic                                be_req_ready_i,
    input  idma_rsp_t                           be_rsp_i,
    input  logic                                be_rsp_valid_i,
    output logic                                be_rsp_ready_o,

    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
    output logic                                busy_o,
    output logic                                rsp_orphan_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    typedef enum logic {SrcTx = 1'b0, SrcRx = 1'b1} src_e;
    typedef enum logic [0:0] {StIdle, StLock} state_e;

    state_e                    state_q, state_d;
    src_e                      grant_q, grant_d;
    src_e                      ptr_q, ptr_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    // Source of each in-flight transfer, oldest at bit 0.
    logic [MaxOutstanding-1:0] fifo_q, fifo_d;

    src_e                      winner;
    src_e                      head;
    logic                      can_grant;
    logic                      gnt_valid;
    logic                      req_hs;
    logic                      rsp_hs;
    logic                      fifo_empty;
    logic [CntW-1:0]           wr_idx;

    assign fifo_empty = (cnt_q == '0);
    assign head       = src_e'(fifo_q[0]);
    assign can_grant  = (cnt_q < CntW'(MaxOutstanding)) && (tx_req_valid_i || rx_req_valid_i);
    assign gnt_valid  = (grant_q == SrcRx) ? rx_req_valid_i : tx_req_valid_i;
    assign req_hs     = (state_q == StLock) && gnt_valid && be_req_ready_i;
    assign rsp_hs     = be_rsp_valid_i && be_rsp_ready_o && !fifo_empty;

    // Arbitration among the requesters valid in IDLE.
    always_comb begin
        winner = SrcTx;
`ifdef ETH_IDMA_SCHED_RX_PRIO_EN
        if (rx_req_valid_i) begin
            winner = SrcRx;
        end
`else
        if (tx_req_valid_i && rx_req_valid_i) begin
            winner = ptr_q;
        end else if (rx_req_valid_i) begin
            winner = SrcRx;
        end
`endif
    end

    // FSM: state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state and grant capture.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        unique case (state_q)
            StIdle: begin
                if (can_grant) begin
                    state_d = StLock;
                    grant_d = winner;
                end
            end
            StLock: begin
                if (req_hs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs. The payload mux follows grant_q even in IDLE; only valid is gated.
    always_comb begin
        be_req_o       = (grant_q == SrcRx) ? rx_req_i : tx_req_i;
        be_req_valid_o = 1'b0;
        tx_req_ready_o = 1'b0;
        rx_req_ready_o = 1'b0;
        if (state_q == StLock) begin
            be_req_valid_o = gnt_valid;
            if (grant_q == SrcRx) begin
                rx_req_ready_o = be_req_ready_i;
            end else begin
                tx_req_ready_o = be_req_ready_i;
            end
        end
    end

    // Response routing. With nothing outstanding the response is swallowed
    // (ready mirrors valid so ready stays low while the channel is idle).
    always_comb begin
        tx_rsp_valid_o = 1'b0;
        rx_rsp_valid_o = 1'b0;
        be_rsp_ready_o = be_rsp_valid_i;
        if (!fifo_empty) begin
            if (head == SrcRx) begin
                rx_rsp_valid_o = be_rsp_valid_i;
                be_rsp_ready_o = rx_rsp_ready_i;
            end else begin
                tx_rsp_valid_o = be_rsp_valid_i;
                be_rsp_ready_o = tx_rsp_ready_i;
            end
        end
    end

    assign tx_rsp_o     = be_rsp_i;
    assign rx_rsp_o     = be_rsp_i;
    assign rsp_orphan_o = be_rsp_valid_i && fifo_empty;

    // Source FIFO as a shift register: pop shifts toward bit 0, push lands
    // just past the surviving entries. A push only happens from LOCK, which
    // is entered with a free slot, so wr_idx is always in range.
    always_comb begin
        fifo_d = fifo_q;
        if (rsp_hs) begin
            fifo_d = fifo_q >> 1;
        end
        wr_idx = cnt_q - CntW'(rsp_hs);
        if (req_hs) begin
            for (int unsigned i = 0; i < MaxOutstanding; i++) begin
                if (CntW'(i) == wr_idx) begin
                    fifo_d[i] = grant_q;
                end
            end
        end
    end

    assign cnt_d = cnt_q + CntW'(req_hs) - CntW'(rsp_hs);
    assign ptr_d = req_hs ? ((grant_q == SrcRx) ? SrcTx : SrcRx) : ptr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant_q <= SrcTx;
            ptr_q   <= SrcTx;
            cnt_q   <= '0;
            fifo_q  <= '0;
        end else begin
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            fifo_q  <= fifo_d;
        end
    end

    assign outstanding_o = cnt_q;
    assign busy_o        = (cnt_q != '0) || (state_q == StLock);

endmodule

// File: tb/tb_eth_idma_req_sched.sv
// Testbench for eth_idma_req_sched: directed scenarios plus a randomized
// run checked against a transaction-level reference model (queue of sources
// and an alternating preference).
module tb_eth_idma_req_sched;
    import eth_idma_pkg::*;

    localparam int unsigned MaxOut = 4;
    localparam int unsigned CntW   = $clog2(MaxOut + 1);

    logic            clk;
    logic            rst;
    idma_req_t       tx_req, rx_req, be_req;
    logic            tx_req_valid, tx_req_ready, rx_req_valid, rx_req_ready;
    idma_rsp_t       tx_rsp, rx_rsp, be_rsp;
    logic            tx_rsp_valid, tx_rsp_ready, rx_rsp_valid, rx_rsp_ready;
    logic            be_req_valid, be_req_ready, be_rsp_valid, be_rsp_ready;
    logic [CntW-1:0] outstanding;
    logic            busy, rsp_orphan;

    int n_chk  = 0;
    int n_pass = 0;

    eth_idma_req_sched #(.MaxOutstanding(MaxOut)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .tx_req_i       (tx_req),
        .tx_req_valid_i (tx_req_valid),
        .tx_req_ready_o (tx_req_ready),
        .tx_rsp_o       (tx_rsp),
        .tx_rsp_valid_o (tx_rsp_valid),
        .tx_rsp_ready_i (tx_rsp_ready),
        .rx_req_i       (rx_req),
        .rx_req_valid_i (rx_req_valid),
        .rx_req_ready_o (rx_req_ready),
        .rx_rsp_o       (rx_rsp),
        .rx_rsp_valid_o (rx_rsp_valid),
        .rx_rsp_ready_i (rx_rsp_ready),
        .be_req_o       (be_req),
        .be_req_valid_o (be_req_valid),
        .be_req_ready_i (be_req_ready),
        .be_rsp_i       (be_rsp),
        .be_rsp_valid_i (be_rsp_valid),
        .be_rsp_ready_o (be_rsp_ready),
        .outstanding_o  (outstanding),
        .busy_o         (busy),
        .rsp_orphan_o   (rsp_orphan)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference arbitration rule: 1 = RX wins, 0 = TX wins.
    function automatic bit exp_winner(input bit pref, input bit tx_v, input bit rx_v);
`ifdef ETH_IDMA_SCHED_RX_PRIO_EN
        return rx_v;
`else
        if (tx_v && rx_v) return pref;
        return rx_v;
`endif
    endfunction

    function automatic idma_req_t rand_req();
        idma_req_t r;
        r.src_addr = $urandom();
        r.dst_addr = $urandom();
        r.length   = 16'($urandom_range(1, 2048));
        return r;
    endfunction

    function automatic idma_rsp_t rand_rsp();
        idma_rsp_t r;
        r.error      = 1'($urandom_range(0, 1));
        r.bytes_done = 16'($urandom());
        return r;
    endfunction

    task automatic idle_inputs();
        tx_req       = '0;
        rx_req       = '0;
        tx_req_valid = 1'b0;
        rx_req_valid = 1'b0;
        be_req_ready = 1'b0;
        be_rsp       = '0;
        be_rsp_valid = 1'b0;
        tx_rsp_ready = 1'b0;
        rx_rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Bounded wait for the backend request valid; returns at negedge+1.
    task automatic wait_be_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (be_req_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        tx_req_valid = 1'b1;
        rx_req_valid = 1'b1;
        be_req_ready = 1'b1;
        tx_rsp_ready = 1'b1;
        rx_rsp_ready = 1'b1;
        #1;
        n_chk++;
        if ({be_req_valid, tx_req_ready, rx_req_ready, tx_rsp_valid, rx_rsp_valid,
             be_rsp_ready, busy, rsp_orphan} !== 8'h00)
            $display("FAIL reset_outputs: got %b want 00000000", {be_req_valid, tx_req_ready,
                     rx_req_ready, tx_rsp_valid, rx_rsp_valid, be_rsp_ready, busy, rsp_orphan});
        else n_pass++;
        n_chk++;
        if (outstanding !== '0) $display("FAIL reset_outstanding: got %0d want 0", outstanding);
        else n_pass++;
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        #1;
        n_chk++;
        if ({be_req_valid, busy, be_rsp_ready} !== 3'b000)
            $display("FAIL reset_release: got %b want 000", {be_req_valid, busy, be_rsp_ready});
        else n_pass++;
    endtask

    task automatic test_tx_only();
        idma_req_t req;
        idma_rsp_t rsp;
        do_reset();
        req = rand_req();
        req.length = 16'd64;
        tx_req = req;
        tx_req_valid = 1'b1;
        #1;
        n_chk++;
        if (be_req_valid !== 1'b0) $display("FAIL tx_cycle0_valid: got %b want 0", be_req_valid);
        else n_pass++;
        @(negedge clk);
        #1;
        n_chk++;
        if (be_req_valid !== 1'b1) $display("FAIL tx_cycle1_valid: got %b want 1", be_req_valid);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (be_req !== req) $display("FAIL tx_payload_stable: got %h want %h", be_req, req);
            else n_pass++;
            n_chk++;
            if ({be_req_valid, tx_req_ready} !== 2'b10)
                $display("FAIL tx_stall: got %b want 10", {be_req_valid, tx_req_ready});
            else n_pass++;
            @(negedge clk);
            #1;
        end
        be_req_ready = 1'b1;
        #1;
        n_chk++;
        if ({tx_req_ready, rx_req_ready} !== 2'b10)
            $display("FAIL tx_ready_follow: got %b want 10", {tx_req_ready, rx_req_ready});
        else n_pass++;
        @(negedge clk);
        tx_req_valid = 1'b0;
        be_req_ready = 1'b0;
        #1;
        n_chk++;
        if (outstanding !== CntW'(1)) $display("FAIL tx_outstanding1: got %0d want 1", outstanding);
        else n_pass++;
        rsp = rand_rsp();
        be_rsp = rsp;
        be_rsp_valid = 1'b1;
        tx_rsp_ready = 1'b1;
        rx_rsp_ready = 1'b1;
        #1;
        n_chk++;
        if ({tx_rsp_valid, rx_rsp_valid, be_rsp_ready} !== 3'b101)
            $display("FAIL tx_rsp_route: got %b want 101", {tx_rsp_valid, rx_rsp_valid, be_rsp_ready});
        else n_pass++;
        n_chk++;
        if (tx_rsp !== rsp) $display("FAIL tx_rsp_data: got %h want %h", tx_rsp, rsp);
        else n_pass++;
        @(negedge clk);
        be_rsp_valid = 1'b0;
        #1;
        n_chk++;
        if ({outstanding, busy} !== {CntW'(0), 1'b0})
            $display("FAIL tx_drained: got %0d/%b want 0/0", outstanding, busy);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_round_robin();
        bit q[$];
        bit pref, exp, dst, acc;
        int grants;
        do_reset();
        pref = 1'b0;
        grants = 0;
        tx_req = rand_req();
        rx_req = rand_req();
        tx_req_valid = 1'b1;
        rx_req_valid = 1'b1;
        be_req_ready = 1'b1;
        tx_rsp_ready = 1'b1;
        rx_rsp_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            be_rsp_valid = (q.size() != 0);
            be_rsp = rand_rsp();
            #1;
            if (be_rsp_valid) begin
                dst = q.pop_front();
                n_chk++;
                if ({tx_rsp_valid, rx_rsp_valid} !== (dst ? 2'b01 : 2'b10))
                    $display("FAIL rr_rsp_route: got %b want dst %0d", {tx_rsp_valid, rx_rsp_valid}, dst);
                else n_pass++;
            end
            acc = be_req_valid;
            exp = exp_winner(pref, 1'b1, 1'b1);
            if (acc) begin
                n_chk++;
                if ({rx_req_ready, tx_req_ready} !== (exp ? 2'b10 : 2'b01))
                    $display("FAIL rr_grant: got rx/tx %b want winner %0d", {rx_req_ready, tx_req_ready}, exp);
                else n_pass++;
                n_chk++;
                if (be_req !== (exp ? rx_req : tx_req)) $display("FAIL rr_payload: got %h", be_req);
                else n_pass++;
                q.push_back(exp);
                pref = ~exp;
                grants++;
            end
            @(negedge clk);
            if (acc) begin
                if (exp) rx_req = rand_req();
                else tx_req = rand_req();
            end
        end
        n_chk++;
        if (grants != 8) $display("FAIL rr_grant_count: got %0d want 8", grants);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_full();
        bit q[$];
        bit pref, exp, dst, acc;
        int extra;
        do_reset();
        pref = 1'b0;
        tx_req = rand_req();
        rx_req = rand_req();
        tx_req_valid = 1'b1;
        rx_req_valid = 1'b1;
        be_req_ready = 1'b1;
        tx_rsp_ready = 1'b1;
        rx_rsp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            acc = be_req_valid;
            exp = exp_winner(pref, 1'b1, 1'b1);
            if (acc) begin
                n_chk++;
                if ({rx_req_ready, tx_req_ready} !== (exp ? 2'b10 : 2'b01))
                    $display("FAIL full_grant: got rx/tx %b want winner %0d", {rx_req_ready, tx_req_ready}, exp);
                else n_pass++;
                q.push_back(exp);
                pref = ~exp;
            end
            @(negedge clk);
            if (acc) begin
                if (exp) rx_req = rand_req();
                else tx_req = rand_req();
            end
        end
        #1;
        n_chk++;
        if (q.size() != MaxOut) $display("FAIL full_accept_count: got %0d want %0d", q.size(), MaxOut);
        else n_pass++;
        n_chk++;
        if (outstanding !== CntW'(MaxOut))
            $display("FAIL full_outstanding: got %0d want %0d", outstanding, MaxOut);
        else n_pass++;
        n_chk++;
        if ({tx_req_ready, rx_req_ready, be_req_valid, busy} !== 4'b0001)
            $display("FAIL full_blocked: got %b want 0001", {tx_req_ready, rx_req_ready, be_req_valid, busy});
        else n_pass++;
        be_rsp = rand_rsp();
        be_rsp_valid = 1'b1;
        #1;
        dst = q.pop_front();
        n_chk++;
        if ({tx_rsp_valid, rx_rsp_valid, tx_req_ready, rx_req_ready} !== (dst ? 4'b0100 : 4'b1000))
            $display("FAIL full_rsp: got %b want dst %0d", {tx_rsp_valid, rx_rsp_valid,
                     tx_req_ready, rx_req_ready}, dst);
        else n_pass++;
        @(negedge clk);
        be_rsp_valid = 1'b0;
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            acc = be_req_valid;
            exp = exp_winner(pref, 1'b1, 1'b1);
            if (acc) begin
                n_chk++;
                if ({rx_req_ready, tx_req_ready} !== (exp ? 2'b10 : 2'b01))
                    $display("FAIL full_regrant: got rx/tx %b want winner %0d", {rx_req_ready, tx_req_ready}, exp);
                else n_pass++;
                pref = ~exp;
                extra++;
            end
            @(negedge clk);
        end
        #1;
        n_chk++;
        if (extra != 1) $display("FAIL full_one_more: got %0d grants want 1", extra);
        else n_pass++;
        n_chk++;
        if (outstanding !== CntW'(MaxOut))
            $display("FAIL full_refilled: got %0d want %0d", outstanding, MaxOut);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_simul();
        bit q[$];
        bit pref, exp, dst, ok;
        do_reset();
        pref = 1'b0;
        tx_req = rand_req();
        rx_req = rand_req();
        tx_req_valid = 1'b1;
        rx_req_valid = 1'b1;
        tx_rsp_ready = 1'b1;
        rx_rsp_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_be_valid(ok);
            n_chk++;
            if (!ok) $display("FAIL simul_wait_grant: got timeout want be_req_valid");
            else n_pass++;
            exp = exp_winner(pref, 1'b1, 1'b1);
            be_req_ready = 1'b1;
            #1;
            n_chk++;
            if ({rx_req_ready, tx_req_ready} !== (exp ? 2'b10 : 2'b01))
                $display("FAIL simul_grant: got rx/tx %b want winner %0d", {rx_req_ready, tx_req_ready}, exp);
            else n_pass++;
            q.push_back(exp);
            pref = ~exp;
            @(negedge clk);
            be_req_ready = 1'b0;
            if (exp) rx_req = rand_req();
            else tx_req = rand_req();
        end
        #1;
        n_chk++;
        if (outstanding !== CntW'(2)) $display("FAIL simul_pre: got %0d want 2", outstanding);
        else n_pass++;
        wait_be_valid(ok);
        n_chk++;
        if (!ok) $display("FAIL simul_wait_third: got timeout want be_req_valid");
        else n_pass++;
        exp = exp_winner(pref, 1'b1, 1'b1);
        be_req_ready = 1'b1;
        be_rsp = rand_rsp();
        be_rsp_valid = 1'b1;
        #1;
        dst = q.pop_front();
        n_chk++;
        if ({tx_rsp_valid, rx_rsp_valid, be_rsp_ready} !== (dst ? 3'b011 : 3'b101))
            $display("FAIL simul_rsp: got %b want dst %0d", {tx_rsp_valid, rx_rsp_valid, be_rsp_ready}, dst);
        else n_pass++;
        n_chk++;
        if ({rx_req_ready, tx_req_ready} !== (exp ? 2'b10 : 2'b01))
            $display("FAIL simul_req: got rx/tx %b want winner %0d", {rx_req_ready, tx_req_ready}, exp);
        else n_pass++;
        q.push_back(exp);
        @(negedge clk);
        idle_inputs();
        tx_rsp_ready = 1'b1;
        rx_rsp_ready = 1'b1;
        #1;
        n_chk++;
        if (outstanding !== CntW'(2)) $display("FAIL simul_post: got %0d want 2", outstanding);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            be_rsp = rand_rsp();
            be_rsp_valid = 1'b1;
            #1;
            dst = q.pop_front();
            n_chk++;
            if ({tx_rsp_valid, rx_rsp_valid} !== (dst ? 2'b01 : 2'b10))
                $display("FAIL simul_order: got %b want dst %0d", {tx_rsp_valid, rx_rsp_valid}, dst);
            else n_pass++;
            @(negedge clk);
        end
        be_rsp_valid = 1'b0;
        #1;
        n_chk++;
        if (outstanding !== '0) $display("FAIL simul_drained: got %0d want 0", outstanding);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_orphan();
        do_reset();
        be_rsp = rand_rsp();
        be_rsp_valid = 1'b1;
        tx_rsp_ready = 1'b0;
        rx_rsp_ready = 1'b0;
        #1;
        n_chk++;
        if ({be_rsp_ready, rsp_orphan, tx_rsp_valid, rx_rsp_valid} !== 4'b1100)
            $display("FAIL orphan_pulse: got %b want 1100", {be_rsp_ready, rsp_orphan,
                     tx_rsp_valid, rx_rsp_valid});
        else n_pass++;
        @(negedge clk);
        be_rsp_valid = 1'b0;
        #1;
        n_chk++;
        if ({be_rsp_ready, rsp_orphan, outstanding} !== {2'b00, CntW'(0)})
            $display("FAIL orphan_after: got %b/%b/%0d want 0/0/0", be_rsp_ready, rsp_orphan, outstanding);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        tx_req = rand_req();
        rx_req = rand_req();
        tx_req_valid = 1'b1;
        rx_req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_be_valid(ok);
            be_req_ready = 1'b1;
            @(negedge clk);
            be_req_ready = 1'b0;
        end
        wait_be_valid(ok);
        n_chk++;
        if (!ok || outstanding !== CntW'(3))
            $display("FAIL rstmid_setup: got lock=%b outstanding=%0d want 1/3", ok, outstanding);
        else n_pass++;
        be_req_ready = 1'b1;
        rst = 1'b1;
        #1;
        n_chk++;
        if ({be_req_valid, tx_req_ready, rx_req_ready, tx_rsp_valid, rx_rsp_valid,
             be_rsp_ready, busy, rsp_orphan} !== 8'h00 || outstanding !== '0)
            $display("FAIL rstmid_outputs: got %b/%0d want 0/0", {be_req_valid, tx_req_ready,
                     rx_req_ready, tx_rsp_valid, rx_rsp_valid, be_rsp_ready, busy, rsp_orphan},
                     outstanding);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1;
        n_chk++;
        if ({outstanding, busy} !== {CntW'(0), 1'b0})
            $display("FAIL rstmid_release: got %0d/%b want 0/0", outstanding, busy);
        else n_pass++;
        be_rsp = rand_rsp();
        be_rsp_valid = 1'b1;
        tx_rsp_ready = 1'b1;
        rx_rsp_ready = 1'b1;
        #1;
        n_chk++;
        if ({rsp_orphan, be_rsp_ready, tx_rsp_valid, rx_rsp_valid} !== 4'b1100)
            $display("FAIL rstmid_late_rsp: got %b want 1100", {rsp_orphan, be_rsp_ready,
                     tx_rsp_valid, rx_rsp_valid});
        else n_pass++;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_random();
        bit q[$];
        bit pref, exp, dst, acc, last_acc, exp_rdy;
        int accepts;
        do_reset();
        pref = 1'b0;
        last_acc = 1'b0;
        accepts = 0;
        tx_req = rand_req();
        rx_req = rand_req();
        tx_req_valid = 1'b1;
        rx_req_valid = 1'b1;
        for (int c = 0; c < 600; c++) begin
            be_req_ready = 1'($urandom_range(0, 1));
            be_rsp_valid = ($urandom_range(0, 9) < 4);
            be_rsp = rand_rsp();
            tx_rsp_ready = 1'($urandom_range(0, 1));
            rx_rsp_ready = 1'($urandom_range(0, 1));
            #1;
            n_chk++;
            if (outstanding !== CntW'(q.size()))
                $display("FAIL rand_outstanding: got %0d want %0d", outstanding, q.size());
            else n_pass++;
            acc = be_req_valid && be_req_ready;
            exp = exp_winner(pref, 1'b1, 1'b1);
            if (acc) begin
                n_chk++;
                if (last_acc || q.size() >= MaxOut)
                    $display("FAIL rand_accept_rule: got accept (prev=%b, inflight=%0d)", last_acc, q.size());
                else n_pass++;
                n_chk++;
                if ({rx_req_ready, tx_req_ready} !== (exp ? 2'b10 : 2'b01))
                    $display("FAIL rand_grant: got rx/tx %b want winner %0d", {rx_req_ready, tx_req_ready}, exp);
                else n_pass++;
                n_chk++;
                if (be_req !== (exp ? rx_req : tx_req)) $display("FAIL rand_payload: got %h", be_req);
                else n_pass++;
            end else begin
                n_chk++;
                if ({rx_req_ready, tx_req_ready} !== 2'b00)
                    $display("FAIL rand_idle_ready: got %b want 00", {rx_req_ready, tx_req_ready});
                else n_pass++;
            end
            if (be_rsp_valid && q.size() == 0) begin
                n_chk++;
                if ({be_rsp_ready, rsp_orphan, tx_rsp_valid, rx_rsp_valid} !== 4'b1100)
                    $display("FAIL rand_orphan: got %b want 1100", {be_rsp_ready, rsp_orphan,
                             tx_rsp_valid, rx_rsp_valid});
                else n_pass++;
            end else if (be_rsp_valid) begin
                dst = q[0];
                exp_rdy = dst ? rx_rsp_ready : tx_rsp_ready;
                n_chk++;
                if ({tx_rsp_valid, rx_rsp_valid, rsp_orphan, be_rsp_ready} !==
                    {~dst, dst, 1'b0, exp_rdy})
                    $display("FAIL rand_rsp_route: got %b want dst %0d rdy %b", {tx_rsp_valid,
                             rx_rsp_valid, rsp_orphan, be_rsp_ready}, dst, exp_rdy);
                else n_pass++;
                n_chk++;
                if ((dst ? rx_rsp : tx_rsp) !== be_rsp)
                    $display("FAIL rand_rsp_data: got %h want %h", (dst ? rx_rsp : tx_rsp), be_rsp);
                else n_pass++;
                if (exp_rdy) void'(q.pop_front());
            end else begin
                n_chk++;
                if ({tx_rsp_valid, rx_rsp_valid, rsp_orphan} !== 3'b000)
                    $display("FAIL rand_rsp_quiet: got %b want 000", {tx_rsp_valid, rx_rsp_valid, rsp_orphan});
                else n_pass++;
            end
            if (acc) begin
                q.push_back(exp);
                pref = ~exp;
                accepts++;
            end
            last_acc = acc;
            @(negedge clk);
            if (acc) begin
                if (exp) rx_req = rand_req();
                else tx_req = rand_req();
            end
        end
        n_chk++;
        if (accepts <= 20) $display("FAIL rand_progress: got %0d accepts want > 20", accepts);
        else n_pass++;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_tx_only();
        test_round_robin();
        test_full();
        test_simul();
        test_orphan();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
